rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Registered, parametrised N-channel datapath multiplexer with per-channel valid/ready handshakes and a selectable fixed-select or round-robin arbitration mode. It generalises the combinational 8-to-1 32-bit operand mux into a flow-controlled stage. It sits between multiple ALU/result producers and a single consumer such as a writeback or forwarding bus. The output is held in a one-entry register, so back-pressure never corrupts data.

## Interface
- WIDTH, 32, data word width in bits
- NCH, 8, number of input channels (2..16)
- SELW, $clog2(NCH), width of the select and channel-tag fields
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  channel i presents a word
- in_ready  output  NCH  channel i word is accepted this cycle (combinational)
- mode  input  1  0 = fixed select via sel, 1 = round-robin
- sel  input  SELW  channel selected in fixed mode
- out_data  output  WIDTH  registered word
- out_ch  output  SELW  source channel of out_data
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Load enable: load_ok = !out_valid | out_ready.
- Fixed mode: grant goes to channel sel when in_valid[sel] is high. If sel >= NCH, there is no grant.
- Round-robin mode: grant goes to the first channel with valid set, scanning from ptr+1 upward, modulo NCH.
- Handshake: in_ready[i] = grant[i] & load_ok. At most one bit is set, and it is never set for an invalid channel.
- Accepted transfer, when the granted channel's in_valid and in_ready are both high:
  - out_data is loaded from that channel;
  - out_ch is set to the channel index;
  - out_valid is set to 1;
  - in round-robin mode, ptr is set to that index.
- Drain without refill, when out_valid, out_ready and no grant: out_valid goes to 0. out_data and out_ch hold their values.
- Simultaneous drain and load: the new word replaces the old one with no bubble, and out_valid stays 1.
- Stall, when out_valid is high and out_ready is low: in_ready is all zero, and out_data and out_ch are stable.
- Mode or sel changes take effect on the next arbitration. A held word is never altered.
- In fixed mode ptr does not update; it keeps its last value.

## Timing
- Reset values:
  - out_valid = 0
  - out_data = 0
  - out_ch = 0
  - ptr = NCH-1, so channel 0 has first priority
  - in_ready = 0 while rst_n is low
- Latency is 1 cycle from the accepting edge to out_valid.
- Full throughput: one word per cycle while out_ready is held high.
- Reset asserted mid-operation discards the held word immediately (asynchronously). There is no output glitch after release.
- The grant path is combinational from in_valid, mode, sel and ptr. There is no combinational path from in_data to any output.

## Configuration
- RR_ARB_MUX_RR_EN defined: round-robin logic and ptr are built, and mode is honoured.
- RR_ARB_MUX_RR_EN undefined: the mode input is ignored and the block always operates in fixed-select mode. ptr and the rotating scan are not synthesised.

## Structure
- Package rr_mux_pkg holds:
  - mode encodings MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - the default WIDTH and NCH constants;
  - a clog2 helper function.
- Sub-module rr_arbiter: takes NCH request bits and ptr, and returns a one-hot grant and an encoded index. It is instantiated only under RR_ARB_MUX_RR_EN.
- The top level contains the fixed-select decode, the grant mux, the load_ok logic and the output register.

## Test plan
- Fixed select, no back-pressure:
  - stimulus: NCH=8, WIDTH=32, channel i drives 32'hiiiiiiii (0x00000000 .. 0x77777777), all channels valid, out_ready=1, sel stepped 0..7 one per cycle;
  - response: out_data follows 1 cycle later, 0x00000000 .. 0x77777777, and out_ch = 0..7.
- Round robin, all valid:
  - stimulus: mode=1, all 8 channels valid, out_ready=1;
  - response: out_ch sequence 0,1,...,7,0, with in_ready one-hot rotating each cycle.
- Round robin, sparse requests:
  - stimulus: only channels 2 and 5 valid;
  - response: out_ch alternates 2,5,2,5 and in_ready never asserts for any other channel.
- Back-pressure:
  - stimulus: out_valid high and out_ready low for 3 cycles;
  - response: in_ready = 0, and out_data and out_ch stay stable;
  - release: out_ready rises and a new word loads on the same edge as the drain, with no bubble.
- Fixed-select corner cases:
  - stimulus: sel=3 with in_valid[3]=0;
  - response: no transfer, and out_valid drops after the drain;
  - with NCH=6 and sel=7: no grant ever.
- Reset mid-operation:
  - stimulus: assert rst_n low while holding 0x55555555;
  - response: out_valid=0 and out_data=0 immediately;
  - after release in round-robin mode, channel 0 is granted first.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants for the rr_arb_mux operand multiplexer: mode encodings,
// default geometry and a constant-evaluable ceil(log2) helper.
package rr_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH   = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the first requester found scanning upward from
// ptr+1 (modulo NCH) wins; produces a one-hot grant and its encoded index.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] idx,
    output logic            gnt_vld
);

    always_comb begin
        gnt     = '0;
        idx     = '0;
        gnt_vld = 1'b0;
        // Offsets 1..NCH visit every channel once, ending on ptr itself.
        for (int k = 1; k <= NCH; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!gnt_vld && req[i] && (i == (int'(ptr) + k) % NCH)) begin
                    gnt[i]  = 1'b1;
                    idx     = SELW'(i);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Flow-controlled N-to-1 operand mux with a one-entry output register.
// Round-robin arbitration is built only when RR_ARB_MUX_RR_EN is defined.
module rr_arb_mux
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [NCH-1:0]   fix_gnt;
    logic [SELW-1:0]  fix_idx;
    logic             fix_vld;
    logic [NCH-1:0]   gnt;
    logic [SELW-1:0]  gidx;
    logic             gnt_vld;
    logic             load_ok;
    logic             accept;
    logic [WIDTH-1:0] gnt_word;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;

    // An out-of-range sel matches no loop index, so it never grants.
    always_comb begin
        fix_gnt = '0;
        fix_idx = '0;
        fix_vld = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                fix_gnt[i] = 1'b1;
                fix_idx    = SELW'(i);
                fix_vld    = 1'b1;
            end
        end
    end

`ifdef RR_ARB_MUX_RR_EN
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [NCH-1:0]  rr_gnt;
    logic [SELW-1:0] rr_idx;
    logic            rr_vld;
    logic            rr_mode;

    assign rr_mode = (mode == MODE_RR);

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .idx     (rr_idx),
        .gnt_vld (rr_vld)
    );

    assign gnt     = rr_mode ? rr_gnt : fix_gnt;
    assign gidx    = rr_mode ? rr_idx : fix_idx;
    assign gnt_vld = rr_mode ? rr_vld : fix_vld;

    always_comb begin
        ptr_d = ptr_q;
        if (accept && rr_mode) ptr_d = gidx;
    end

    // Reset to NCH-1 so the first scan starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= SELW'(NCH - 1);
        else        ptr_q <= ptr_d;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    assign gnt     = fix_gnt;
    assign gidx    = fix_idx;
    assign gnt_vld = fix_vld;
`endif

    assign load_ok  = !out_valid_q || out_ready;
    assign accept   = gnt_vld && load_ok && rst_n;
    assign in_ready = gnt & {NCH{load_ok && rst_n}};

    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gidx == SELW'(i)) gnt_word = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = gnt_word;
            out_ch_d    = gidx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: hand-written vector table, round-robin sequences,
// randomized traffic against a behavioural model, NCH=6 and reset corners.
module tb_rr_arb_mux;

    localparam bit RR_EN =
`ifdef RR_ARB_MUX_RR_EN
        1'b1;
`else
        1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] in_data = '0;
    logic [7:0]   in_valid = '0;
    logic [7:0]   in_ready;
    logic         mode = 1'b0;
    logic [2:0]   sel = '0;
    logic [31:0]  out_data;
    logic [2:0]   out_ch;
    logic         out_valid;
    logic         out_ready = 1'b0;

    logic [191:0] in6_data = '0;
    logic [5:0]   in6_valid = '0;
    logic [5:0]   in6_ready;
    logic [2:0]   sel6 = '0;
    logic [31:0]  out6_data;
    logic [2:0]   out6_ch;
    logic         out6_valid;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(32), .NCH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(32), .NCH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in6_data), .in_valid(in6_valid),
        .in_ready(in6_ready), .mode(1'b0), .sel(sel6), .out_data(out6_data),
        .out_ch(out6_ch), .out_valid(out6_valid), .out_ready(1'b1)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: holding register contents plus the last RR winner.
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic [2:0]  m_ch = '0;
    int          m_ptr = 7;
    int          m_g;
    bit          m_lok;
    logic [7:0]  m_rdy;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = '0;
        m_ptr   = 7;
    endtask

    task automatic model_grant();
        m_g = -1;
        m_lok = !m_valid || out_ready;
        if (RR_EN && mode) begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (m_g < 0 && in_valid[c]) m_g = c;
            end
        end else if (in_valid[sel]) begin
            m_g = int'(sel);
        end
        m_rdy = (m_g >= 0 && m_lok) ? 8'(1 << m_g) : 8'h00;
    endtask

    task automatic model_commit();
        if (m_g >= 0 && m_lok) begin
            m_valid = 1'b1;
            m_data  = in_data[m_g*32 +: 32];
            m_ch    = 3'(m_g);
            if (RR_EN && mode) m_ptr = m_g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    logic [7:0]  s_rdy;
    logic        s_ov;
    logic [2:0]  s_ch;
    logic [31:0] s_data;

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic run_cycle(input bit vs_model);
        #1;
        model_grant();
        s_rdy = in_ready;
        if (vs_model) chk("in_ready", 32'(in_ready), 32'(m_rdy));
        @(posedge clk);
        model_commit();
        @(negedge clk);
        s_ov   = out_valid;
        s_ch   = out_ch;
        s_data = out_data;
        if (vs_model) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_ch", 32'(out_ch), 32'(m_ch));
            chk("out_data", out_data, m_data);
        end
    endtask

    task automatic set_pattern();
        for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'(32'h11111111 * i);
        for (int i = 0; i < 6; i++) in6_data[i*32 +: 32] = 32'(32'h11111111 * i);
    endtask

    typedef struct {
        logic        mode;
        logic [2:0]  sel;
        logic [7:0]  vld;
        logic        rdy;
        logic [7:0]  e_rdy;
        logic        e_ov;
        logic [2:0]  e_ch;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic [2:0] s, input logic [7:0] v,
                                input logic r, input logic [7:0] er, input logic eo,
                                input logic [2:0] ec, input logic [31:0] ed);
        vec_t t;
        t.mode = m; t.sel = s; t.vld = v; t.rdy = r;
        t.e_rdy = er; t.e_ov = eo; t.e_ch = ec; t.e_data = ed;
        return t;
    endfunction

    vec_t tbl[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1'b0, 3'(i), 8'hFF, 1'b1, 8'(1 << i), 1'b1, 3'(i), 32'(32'h11111111 * i));
        tbl[8]  = mk(1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 3'd7, 32'h77777777);
        tbl[9]  = mk(1'b0, 3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 32'h33333333);
        tbl[10] = mk(1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 32'h33333333);
        tbl[11] = mk(1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 32'h33333333);
        tbl[12] = mk(1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 32'h33333333);
        tbl[13] = mk(1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 32'h55555555);
        tbl[14] = mk(1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 32'h55555555);
        tbl[15] = mk(1'b0, 3'd5, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 32'h55555555);
        tbl[16] = mk(1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 1'b0, 3'd5, 32'h55555555);

        set_pattern();
        in_valid = 8'hFF;
        model_reset();

        // Reset state, including in_ready suppression while rst_n is low.
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_in6_ready", 32'(in6_ready), 32'd0);
        rst_n = 1'b1;

        // Table: fixed sweep, missing-valid drain, back-pressure and release.
        for (int t = 0; t < 17; t++) begin
            mode = tbl[t].mode; sel = tbl[t].sel;
            in_valid = tbl[t].vld; out_ready = tbl[t].rdy;
            run_cycle(1'b0);
            chk($sformatf("tbl%0d_in_ready", t), 32'(s_rdy), 32'(tbl[t].e_rdy));
            chk($sformatf("tbl%0d_out_valid", t), 32'(s_ov), 32'(tbl[t].e_ov));
            chk($sformatf("tbl%0d_out_ch", t), 32'(s_ch), 32'(tbl[t].e_ch));
            chk($sformatf("tbl%0d_out_data", t), s_data, tbl[t].e_data);
        end

`ifdef RR_ARB_MUX_RR_EN
        // Round robin, all channels requesting: 0..7 then wrap to 0.
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            run_cycle(1'b0);
            chk($sformatf("rr_all%0d_in_ready", k), 32'(s_rdy), 32'(8'(1 << (k % 8))));
            chk($sformatf("rr_all%0d_out_ch", k), 32'(s_ch), 32'(k % 8));
            chk($sformatf("rr_all%0d_out_data", k), s_data, 32'(32'h11111111 * (k % 8)));
        end
        // Sparse requesters 2 and 5 alternate.
        in_valid = 8'h24;
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b0);
            chk($sformatf("rr_sp%0d_in_ready", k), 32'(s_rdy), (k % 2 == 0) ? 32'h04 : 32'h20);
            chk($sformatf("rr_sp%0d_out_ch", k), 32'(s_ch), (k % 2 == 0) ? 32'd2 : 32'd5);
        end
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom;
            mode      = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            run_cycle(1'b1);
        end

        // NCH=6: select values 6 and 7 are out of range and never grant.
        set_pattern();
        mode = 1'b0; in_valid = 8'h00; out_ready = 1'b1;
        in6_valid = 6'h3F;
        for (int k = 0; k < 4; k++) begin
            sel6 = (k < 2) ? 3'd7 : 3'd6;
            #1;
            chk($sformatf("n6_sel%0d_in_ready", sel6), 32'(in6_ready), 32'd0);
            run_cycle(1'b1);
            chk($sformatf("n6_sel%0d_out_valid", sel6), 32'(out6_valid), 32'd0);
        end
        sel6 = 3'd5;
        #1;
        chk("n6_sel5_in_ready", 32'(in6_ready), 32'h20);
        run_cycle(1'b1);
        chk("n6_sel5_out_valid", 32'(out6_valid), 32'd1);
        chk("n6_sel5_out_ch", 32'(out6_ch), 32'd5);
        chk("n6_sel5_out_data", out6_data, 32'h55555555);
        in6_valid = '0;

        // Reset while holding 0x55555555 clears the register asynchronously.
        mode = 1'b0; sel = 3'd5; in_valid = 8'h20; out_ready = 1'b1;
        run_cycle(1'b1);
        in_valid = 8'h00; out_ready = 1'b0;
        run_cycle(1'b1);
        chk("hold_data", out_data, 32'h55555555);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", out_data, 32'd0);
        in_valid = 8'hFF;
        #1;
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        mode = 1'b1; sel = 3'd4; out_ready = 1'b1;
        run_cycle(1'b1);
        chk("post_rst_in_ready", 32'(s_rdy), RR_EN ? 32'h01 : 32'h10);
        chk("post_rst_out_ch", 32'(s_ch), RR_EN ? 32'd0 : 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
